// File: rtl/afpm_op_sequencer.sv
// Byte-serial operand/result sequencer for the 16-bit log-domain FP multiplier.
// Optional build macro ZERO_BYPASS_EN: zero operands skip the multiplier entirely.
module afpm_op_sequencer #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  a_byte,
    input  logic [7:0]  b_byte,
    output logic        in_ready,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_start,
    input  logic        mul_done,
    input  logic [15:0] mul_result,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        err,
    output logic [7:0]  op_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        SEND  = 3'd4
    } state_t;

    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [15:0] QNAN      = 16'h7E00;

    state_t      state_reg;
    logic [15:0] mul_a_reg;
    logic [15:0] mul_b_reg;
    logic [15:0] result_reg;
    logic [7:0]  wait_cnt_reg;
    logic [7:0]  op_count_reg;
    logic [7:0]  out_byte_reg;
    logic        out_hi_reg;
    logic        out_valid_reg;
    logic        in_ready_reg;
    logic        mul_start_reg;
    logic        busy_reg;
    logic        err_reg;
    logic        bypass;

`ifdef ZERO_BYPASS_EN
    // Evaluated against the operand as it will look once the high byte lands.
    logic [15:0] a_full;
    logic [15:0] b_full;
    assign a_full = {a_byte, mul_a_reg[7:0]};
    assign b_full = {b_byte, mul_b_reg[7:0]};
    assign bypass = (a_full[14:0] == 15'd0) || (b_full[14:0] == 15'd0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mul_a_reg     <= 16'h0000;
            mul_b_reg     <= 16'h0000;
            result_reg    <= 16'h0000;
            wait_cnt_reg  <= 8'd0;
            op_count_reg  <= 8'd0;
            out_byte_reg  <= 8'h00;
            out_hi_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            mul_start_reg <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        mul_a_reg[7:0] <= a_byte;
                        mul_b_reg[7:0] <= b_byte;
                        busy_reg       <= 1'b1;
                        state_reg      <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready_reg) begin
                        mul_a_reg[15:8] <= a_byte;
                        mul_b_reg[15:8] <= b_byte;
                        in_ready_reg    <= 1'b0;
                        if (bypass) begin
                            result_reg    <= {a_byte[7] ^ b_byte[7], 15'd0};
                            out_byte_reg  <= 8'h00;
                            out_hi_reg    <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= SEND;
                        end else begin
                            mul_start_reg <= 1'b1;
                            state_reg     <= START;
                        end
                    end
                end
                START: begin
                    mul_start_reg <= 1'b0;
                    wait_cnt_reg  <= 8'd0;
                    state_reg     <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still delivers its result.
                    if (mul_done) begin
                        result_reg    <= mul_result;
                        out_byte_reg  <= mul_result[7:0];
                        out_hi_reg    <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= SEND;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        result_reg    <= QNAN;
                        out_byte_reg  <= QNAN[7:0];
                        out_hi_reg    <= 1'b0;
                        out_valid_reg <= 1'b1;
                        err_reg       <= 1'b1;
                        state_reg     <= SEND;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (!out_hi_reg) begin
                            out_byte_reg <= result_reg[15:8];
                            out_hi_reg   <= 1'b1;
                        end else begin
                            out_valid_reg <= 1'b0;
                            op_count_reg  <= op_count_reg + 8'd1;
                            in_ready_reg  <= 1'b1;
                            busy_reg      <= 1'b0;
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    mul_start_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;
    assign mul_start = mul_start_reg;
    assign out_byte  = out_byte_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign err       = err_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_afpm_op_sequencer.sv
// Scoreboard bench for afpm_op_sequencer: a behavioural multiplier answers two
// cycles after each start pulse; expected result bytes are queued as operands go in.
module tb_afpm_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic        in_ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_start;
    logic        mul_done;
    logic [15:0] mul_result = 16'h0000;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err;
    logic [7:0]  op_count;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    int          start_cnt = 0;
    logic [15:0] resp = 16'h0000;
    logic [15:0] resp_lat = 16'h0000;
    bit          hang = 1'b0;
    logic        model_done = 1'b0;
    logic        stray_done = 1'b0;
    int          dly = 0;

    assign mul_done = model_done | stray_done;

    afpm_op_sequencer #(.TIMEOUT_CYC(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a_byte     (a_byte),
        .b_byte     (b_byte),
        .in_ready   (in_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err        (err),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: done pulse in the second cycle after the start cycle.
    always @(posedge clk) begin
        #1;
        model_done = 1'b0;
        if (dly > 0) begin
            dly = dly - 1;
            if (dly == 0) begin
                model_done = 1'b1;
                mul_result = resp_lat;
            end
        end
        if (mul_start === 1'b1) begin
            start_cnt = start_cnt + 1;
            if (!hang) begin
                dly = 2;
                resp_lat = resp;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model_result(input logic [15:0] a, input logic [15:0] b,
                                                 input logic [15:0] r, input bit h);
        logic [15:0] v;
        v = h ? 16'h7E00 : r;
`ifdef ZERO_BYPASS_EN
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0)
            v = {a[15] ^ b[15], 15'd0};
`endif
        return v;
    endfunction

    // Called at a falling edge; returns at the falling edge after the beat was taken.
    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        a_byte   = a;
        b_byte   = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 50) begin
            bad++;
            $display("FAIL beat_accept got=in_ready_low want=accepted a=%02h b=%02h", a, b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] r, input bit push);
        logic [15:0] e;
        resp = r;
        if (push) begin
            e = model_result(a, b, r, hang);
            exp_q.push_back(e[7:0]);
            exp_q.push_back(e[15:8]);
        end
        beat(a[7:0], b[7:0]);
        beat(a[15:8], b[15:8]);
    endtask

    task automatic recv_byte(output logic [7:0] got, output bit ok);
        int guard = 0;
        while (out_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok  = (out_valid === 1'b1);
        got = out_byte;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake got=in_ready:%b out_valid:%b busy:%b want=1,0,0",
                     in_ready, out_valid, busy);
        end
        total++;
        if (err !== 1'b0 || mul_start !== 1'b0 || op_count !== 8'd0 || out_byte !== 8'h00) begin
            bad++;
            $display("FAIL reset_flags got=err:%b start:%b cnt:%0d ob:%02h want=0,0,0,00",
                     err, mul_start, op_count, out_byte);
        end
        total++;
        if (mul_a !== 16'h0000 || mul_b !== 16'h0000) begin
            bad++;
            $display("FAIL reset_operands got=%04h/%04h want=0000/0000", mul_a, mul_b);
        end
    endtask

    task automatic test_normal();
        int base;
        logic [7:0] got;
        logic [7:0] e;
        bit ok;
        base = start_cnt;
        send_op(16'h3E00, 16'h4200, 16'h4480, 1'b1);
        total++;
        if (mul_start !== 1'b1 || mul_a !== 16'h3E00 || mul_b !== 16'h4200 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL normal_start got=start:%b a:%04h b:%04h rdy:%b want=1,3e00,4200,0",
                     mul_start, mul_a, mul_b, in_ready);
        end
        @(negedge clk);
        total++;
        if (mul_start !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL normal_start_pulse got=start:%b busy:%b want=0,1", mul_start, busy);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || mul_done !== 1'b1) begin
            bad++;
            $display("FAIL normal_done_cycle got=out_valid:%b done:%b want=0,1", out_valid, mul_done);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL normal_latency got=out_valid:%b want=1", out_valid);
        end
        for (int k = 0; k < 2; k++) begin
            recv_byte(got, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || got !== e) begin
                bad++;
                $display("FAIL normal_byte%0d got=%02h want=%02h ok=%b", k, got, e, ok);
            end
        end
        total++;
        if (op_count !== 8'd1 || start_cnt - base != 1) begin
            bad++;
            $display("FAIL normal_count got=op:%0d starts:%0d want=1,1", op_count, start_cnt - base);
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        logic [7:0] got;
        logic [7:0] e;
        bit ok;
        out_ready = 1'b0;
        send_op(16'h3E00, 16'h4200, 16'h4480, 1'b1);
        while (out_valid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        a_byte   = 8'h55;
        b_byte   = 8'h66;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_byte !== 8'h80 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got=v:%b ob:%02h rdy:%b want=1,80,0",
                         k, out_valid, out_byte, in_ready);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            recv_byte(got, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || got !== e) begin
                bad++;
                $display("FAIL bp_byte%0d got=%02h want=%02h ok=%b", k, got, e, ok);
            end
        end
        total++;
        if (mul_a !== 16'h3E00 || mul_b !== 16'h4200 || op_count !== 8'd2) begin
            bad++;
            $display("FAIL bp_no_consume got=a:%04h b:%04h op:%0d want=3e00,4200,2",
                     mul_a, mul_b, op_count);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] got;
        logic [7:0] e;
        bit ok;
        hang = 1'b1;
        send_op(16'h3C00, 16'h4000, 16'h1234, 1'b1);
        repeat (15) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early got=out_valid:%b want=0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire got=v:%b err:%b want=1,1", out_valid, err);
        end
        for (int k = 0; k < 2; k++) begin
            recv_byte(got, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || got !== e) begin
                bad++;
                $display("FAIL timeout_byte%0d got=%02h want=%02h ok=%b", k, got, e, ok);
            end
        end
        hang = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got=err:%b want=1", err);
        end
        send_op(16'h3C00, 16'h4000, 16'h4000, 1'b1);
        for (int k = 0; k < 2; k++) begin
            recv_byte(got, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || got !== e) begin
                bad++;
                $display("FAIL after_timeout_byte%0d got=%02h want=%02h ok=%b", k, got, e, ok);
            end
        end
        total++;
        if (err !== 1'b1 || op_count !== 8'd4) begin
            bad++;
            $display("FAIL after_timeout_state got=err:%b op:%0d want=1,4", err, op_count);
        end
    endtask

    task automatic test_zero_bypass();
        int base;
        int want_starts;
        logic [7:0] got;
        logic [7:0] e;
        bit ok;
`ifdef ZERO_BYPASS_EN
        want_starts = 0;
`else
        want_starts = 1;
`endif
        base = start_cnt;
        send_op(16'h0000, 16'h0001, 16'h1111, 1'b1);
        for (int k = 0; k < 2; k++) begin
            recv_byte(got, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || got !== e) begin
                bad++;
                $display("FAIL zero_byte%0d got=%02h want=%02h ok=%b", k, got, e, ok);
            end
        end
        total++;
        if (start_cnt - base != want_starts) begin
            bad++;
            $display("FAIL zero_starts got=%0d want=%0d", start_cnt - base, want_starts);
        end
        base = start_cnt;
        send_op(16'h8000, 16'h4200, 16'h2A2A, 1'b1);
        for (int k = 0; k < 2; k++) begin
            recv_byte(got, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || got !== e) begin
                bad++;
                $display("FAIL signzero_byte%0d got=%02h want=%02h ok=%b", k, got, e, ok);
            end
        end
        total++;
        if (start_cnt - base != want_starts || op_count !== 8'd6) begin
            bad++;
            $display("FAIL signzero_state got=starts:%0d op:%0d want=%0d,6",
                     start_cnt - base, op_count, want_starts);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        hang = 1'b1;
        send_op(16'h1234, 16'h5678, 16'h0000, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== 8'd0) begin
            bad++;
            $display("FAIL midreset_idle got=busy:%b rdy:%b v:%b op:%0d want=0,1,0,0",
                     busy, in_ready, out_valid, op_count);
        end
        for (int k = 0; k < 30; k++) begin
            if (out_valid === 1'b1)
                seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen || op_count !== 8'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_quiet got=valid_seen:%b op:%0d busy:%b want=0,0,0",
                     seen, op_count, busy);
        end
        hang = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [7:0] got;
        logic [7:0] e;
        bit ok;
        for (int i = 0; i < 256; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            r = 16'($urandom);
            send_op(a, b, r, 1'b1);
            for (int k = 0; k < 2; k++) begin
                recv_byte(got, ok);
                e = exp_q.pop_front();
                total++;
                if (!ok || got !== e) begin
                    bad++;
                    $display("FAIL b2b_op%0d_byte%0d got=%02h want=%02h ok=%b", i, k, got, e, ok);
                end
            end
            if (i == 127) begin
                total++;
                if (op_count !== 8'd128) begin
                    bad++;
                    $display("FAIL b2b_midcount got=%0d want=128", op_count);
                end
            end
        end
        total++;
        if (op_count !== 8'd0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_wrap got=op:%0d pending:%0d want=0,0", op_count, exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a_byte    = 8'h00;
        b_byte    = 8'h00;
        out_ready = 1'b1;
        test_reset();
        test_normal();
        test_backpressure();
        test_timeout();
        test_zero_bypass();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
